vga_mem_arbiter: RTL
====================

# vga_mem_arbiter

Single-port framebuffer arbiter sitting between the VGA scan-out path and a drawing/CPU master. Display fetches are real-time and always win. The drawing master uses a valid/ready port whose writes can be posted into a small FIFO and drained into idle memory slots. Read data returns one cycle after issue, tagged back to the owning requester. Pixel format is RGB565, matching the 5/6/5 colour outputs.

## Interface
Parameters:
- AW, 17: word address width (320x240 = 76800 words)
- DW, 16: data width (RGB565)
- WBUF_DEPTH, 4: posted-write FIFO depth; power of two, >= 2

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  asynchronous, active-high reset
- disp_req  in  1  display fetch request this cycle
- disp_addr  in  AW  display fetch address
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DW  display read data
- cpu_valid  in  1  master request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  master address
- cpu_wdata  in  DW  master write data
- cpu_ready  out  1  request accepted when valid && ready
- cpu_rvalid  out  1  master read data valid
- cpu_rdata  out  DW  master read data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data; synchronous, valid the cycle after mem_en && !mem_we
- wbuf_level  out  log2(WBUF_DEPTH)+1  FIFO occupancy
- cpu_max_wait  out  16  longest stall seen, in cycles

## Operation
- Memory slot priority, evaluated combinationally each cycle:
  1. disp_req
  2. accepted master read
  3. FIFO head drain
  4. none
- Display slot: mem_en=1, mem_we=0, mem_addr=disp_addr.
- Master write, FIFO enabled: cpu_ready = (wbuf_level < WBUF_DEPTH), using the registered level. Push on accept.
  - A pop in the same cycle does not raise ready.
  - Simultaneous push and pop keeps the level unchanged.
- Master read: cpu_ready = !disp_req && wbuf_level == 0. Reads never bypass posted writes, so read-after-write ordering is preserved.
- Drain: when !disp_req and no master read is accepted and the FIFO is non-empty, issue the head as a write and pop it.
- Return tagging: a 2-bit registered owner tag (NONE/DISP/CPU) records the issuing requester. The next cycle, disp_rvalid or cpu_rvalid is driven from the tag; disp_rdata and cpu_rdata are both driven from mem_rdata.
- cpu_max_wait:
  - An internal counter increments while cpu_valid && !cpu_ready, and clears on accept or when valid drops.
  - cpu_max_wait holds the maximum value reached.
  - Both saturate at 0xFFFF.
- Writes never produce rvalid.

## Timing
- Reset (async assert, sync deassert on clk edge):
  - FIFO empty, wbuf_level=0
  - tag=NONE, disp_rvalid=0, cpu_rvalid=0
  - cpu_max_wait=0
  - While rst is high: cpu_ready=0 and mem_en=0.
- Reset mid-operation: posted writes are discarded, and in-flight read returns are dropped (no rvalid).
- Read latency: issue at cycle N, rvalid at N+1. Back-to-back reads are sustainable every cycle.
- A master request arriving while disp_req is asserted continuously stalls indefinitely; only cpu_max_wait reports it.
- Write latency to RAM with FIFO: 1 cycle minimum after accept, unbounded under display load.
- FIFO pointers wrap modulo WBUF_DEPTH. Level is held in its own register, full = WBUF_DEPTH.

## Configuration
- VGA_ARB_WBUF_EN defined:
  - Posted-write FIFO of WBUF_DEPTH entries, behaving as above.
- VGA_ARB_WBUF_EN undefined:
  - No FIFO; wbuf_level is tied to 0.
  - Writes follow the read rule: cpu_ready = !disp_req, and the write issues to RAM in the accept cycle.
  - Priority becomes display > master (read or write).

## Test plan
- Reset: assert rst mid-burst with 3 writes posted. Required: wbuf_level=0, no rvalid, mem_en=0 during reset; after release, the posted writes never reach RAM.
- Display priority: disp_req=1 for 10 cycles while the master reads 0x00100. Required: cpu_ready=0 for all 10 cycles; read issues on cycle 11; cpu_rvalid on cycle 12; cpu_max_wait=10.
- FIFO full (WBUF_EN, depth 4): 6 writes with disp_req held high. Required: 4 accepted, then cpu_ready=0. After disp_req drops, 4 drain writes on consecutive cycles and the remaining 2 are accepted.
- Ordering: write 0xF800 to 0x00042, then immediately read 0x00042. Required: the read waits for the drain, and cpu_rdata=0xF800.
- Interleave: disp_req alternates every cycle, master reads continuously. Required: every disp_req gets disp_rvalid one cycle later with the correct data; master reads fill only the gaps.
- Without VGA_ARB_WBUF_EN: a write with disp_req=0 gives mem_we=1 in the accept cycle and wbuf_level stays 0.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: display fetch > master read > posted-write drain.
// Optional posted-write FIFO enabled by defining VGA_ARB_WBUF_EN; default build issues writes directly.
module vga_mem_arbiter #(
    parameter int AW         = 17,
    parameter int DW         = 16,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_req,
    input  logic [AW-1:0]                 disp_addr,
    output logic                          disp_rvalid,
    output logic [DW-1:0]                 disp_rdata,
    input  logic                          cpu_valid,
    input  logic                          cpu_we,
    input  logic [AW-1:0]                 cpu_addr,
    input  logic [DW-1:0]                 cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_rvalid,
    output logic [DW-1:0]                 cpu_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic [15:0]                   cpu_max_wait
);
    localparam int LW = $clog2(WBUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    tag_t        r_tag;
    logic        w_accept;
    logic        w_rd_acc;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_max_wait;
    logic [15:0] w_wait_nxt;

    assign w_accept = cpu_valid && cpu_ready;
    assign w_rd_acc = w_accept && !cpu_we;

`ifdef VGA_ARB_WBUF_EN
    localparam int            PW   = $clog2(WBUF_DEPTH);
    localparam logic [LW-1:0] FULL = LW'(WBUF_DEPTH);

    logic [AW-1:0] r_fifo_addr [WBUF_DEPTH];
    logic [DW-1:0] r_fifo_data [WBUF_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    // Reads wait for the FIFO to empty so they can never overtake a posted write.
    always_comb begin
        cpu_ready = 1'b0;
        if (!rst) begin
            if (cpu_we)
                cpu_ready = (r_level < FULL);
            else
                cpu_ready = !disp_req && (r_level == '0);
        end
    end

    assign w_push = w_accept && cpu_we;
    assign w_pop  = !rst && !disp_req && !w_rd_acc && (r_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cpu_addr;
            r_fifo_data[r_wptr] <= cpu_wdata;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = disp_addr;
        mem_wdata = '0;
        if (!rst) begin
            if (disp_req) begin
                mem_en = 1'b1;
            end else if (w_rd_acc) begin
                mem_en   = 1'b1;
                mem_addr = cpu_addr;
            end else if (w_pop) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_fifo_addr[r_rptr];
                mem_wdata = r_fifo_data[r_rptr];
            end
        end
    end

    assign wbuf_level = r_level;
`else
    always_comb begin
        cpu_ready = !rst && !disp_req;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = disp_addr;
        mem_wdata = '0;
        if (!rst) begin
            if (disp_req) begin
                mem_en = 1'b1;
            end else if (w_accept) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
        end
    end

    assign wbuf_level = '0;
`endif

    always_comb begin
        w_wait_nxt = '0;
        if (cpu_valid && !cpu_ready)
            w_wait_nxt = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag      <= TAG_NONE;
            r_wait_cnt <= '0;
            r_max_wait <= '0;
        end else begin
            if (disp_req)
                r_tag <= TAG_DISP;
            else if (w_rd_acc)
                r_tag <= TAG_CPU;
            else
                r_tag <= TAG_NONE;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt > r_max_wait)
                r_max_wait <= w_wait_nxt;
        end
    end

    assign disp_rvalid  = (r_tag == TAG_DISP);
    assign cpu_rvalid   = (r_tag == TAG_CPU);
    assign disp_rdata   = mem_rdata;
    assign cpu_rdata    = mem_rdata;
    assign cpu_max_wait = r_max_wait;

endmodule
